// File: rtl/timer_dev_if.sv
// CPU data-bus port of the countdown timer: word offset, write strobe,
// byte enables, write data and combinational read data.
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, WE, BE, Din, input Dout);
  modport slave  (input Addr, WE, BE, Din, output Dout);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable IRQ.
// Define TIMER_BYTE_WRITE_EN to make CTRL/PRESET writes honour the byte enables.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  logic [1:0]  state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        expire;
  logic [31:0] wmask;
  logic [31:0] preset_wr;
  logic [3:0]  ctrl_wr;

  assign wr_ctrl     = bus.WE && (bus.Addr == A_CTRL);
  assign wr_preset   = bus.WE && (bus.Addr == A_PRESET);
  assign auto_reload = (ctrl_mode == 2'b01);
  assign expire      = (state == CNT) && ctrl_en && (count <= 32'd1);

`ifdef TIMER_BYTE_WRITE_EN
  assign wmask = {{8{bus.BE[3]}}, {8{bus.BE[2]}}, {8{bus.BE[1]}}, {8{bus.BE[0]}}};
`else
  logic unused_be;
  assign unused_be = ^bus.BE;
  assign wmask     = '1;
`endif

  // Unselected bytes keep their old value; CTRL only has storage in byte 0.
  assign preset_wr = (preset & ~wmask) | (bus.Din & wmask);
  assign ctrl_wr   = ({ctrl_im, ctrl_mode, ctrl_en} & ~wmask[3:0]) | (bus.Din[3:0] & wmask[3:0]);

  // NOTE: all state lives in one clocked block using non-blocking assignments,
  // so every right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ctrl_en     <= 1'b0;
      ctrl_mode   <= 2'b00;
      ctrl_im     <= 1'b0;
      preset      <= '0;
      count       <= '0;
      irq_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl_en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count <= 32'd1) begin
            count <= '0;
            state <= INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        INT:     state <= auto_reload ? LOAD : IDLE;
        default: state <= IDLE;
      endcase

      // A software CTRL write overrides the one-shot hardware clear of EN.
      if (wr_ctrl) begin
        {ctrl_im, ctrl_mode, ctrl_en} <= ctrl_wr;
      end else if ((state == INT) && !auto_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_preset) preset <= preset_wr;

      // Expiry has priority over any clearing event in the same cycle.
      if (expire) begin
        irq_pending <= 1'b1;
      end else if (((state == INT) && auto_reload) || wr_ctrl || wr_preset) begin
        irq_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      A_CTRL:   bus.Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      A_PRESET: bus.Dout = preset;
      A_COUNT:  bus.Dout = count;
      default:  bus.Dout = '0;
    endcase
  end

  assign IRQ = irq_pending & ctrl_im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: expected values are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_timer_dev;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [31:0] exp_p;

  timer_dev_if bus ();

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    bus.Addr = a;
    bus.Din  = d;
    bus.BE   = be;
    bus.WE   = 1'b1;
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.BE   = 4'hF;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    sb.push_back('{tag, v});
    bus.Addr = a;
    bus.WE   = 1'b0;
    #1;
    e = sb.pop_front();
    check(e.tag, bus.Dout, e.val);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    exp_t e;
    sb.push_back('{tag, {31'd0, v}});
    e = sb.pop_front();
    check(e.tag, {31'd0, irq}, e.val);
  endtask

  initial begin
    reset    = 1'b1;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.BE   = 4'hF;
    bus.Din  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_rd("rst_ctrl",   A_CTRL,   32'h0);
    chk_rd("rst_preset", A_PRESET, 32'h0);
    chk_rd("rst_count",  A_COUNT,  32'h0);
    chk_rd("rst_rsvd",   A_RSVD,   32'h0);
    chk_irq("rst_irq", 1'b0);

    // Read-only / reserved / upper CTRL bits ignore writes
    wr(A_COUNT, 32'hFFFF_FFFF);
    chk_rd("ro_count", A_COUNT, 32'h0);
    wr(A_RSVD, 32'hFFFF_FFFF);
    chk_rd("ro_rsvd", A_RSVD, 32'h0);
    wr(A_CTRL, 32'hFFFF_FFF8);
    chk_rd("ctrl_upper", A_CTRL, 32'h8);

    // One-shot with interrupt, N = 5
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    chk_irq("os_irq_t0", 1'b0);
    tick(1);
    chk_irq("os_irq_t1", 1'b0);
    tick(1);
    for (int k = 0; k <= 5; k++) begin
      chk_rd("os_count", A_COUNT, 32'(5 - k));
      chk_irq("os_irq", k == 5);
      if (k < 5) tick(1);
    end
    tick(1);
    chk_rd("os_ctrl", A_CTRL, 32'h8);
    chk_irq("os_irq_hold", 1'b1);
    tick(3);
    chk_irq("os_irq_hold2", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("os_irq_clr", 1'b0);
    tick(1);
    chk_irq("os_irq_clr2", 1'b0);

    // Auto-reload, N = 3: period 5, count pattern 3,2,1,0,0(LOAD)
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk_irq("ar_irq", (k % 5) == 0);
      if (k >= 2) begin
        case ((k - 2) % 5)
          0:       chk_rd("ar_count", A_COUNT, 32'd3);
          1:       chk_rd("ar_count", A_COUNT, 32'd2);
          2:       chk_rd("ar_count", A_COUNT, 32'd1);
          default: chk_rd("ar_count", A_COUNT, 32'd0);
        endcase
      end
    end
    wr(A_CTRL, 32'h0);
    tick(2);
    chk_rd("ar_stop_count", A_COUNT, 32'd3);
    chk_irq("ar_stop_irq", 1'b0);

    // Pause at COUNT = 6, PRESET isolation, re-enable with PRESET = 2
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    tick(5);
    chk_rd("pz_count7", A_COUNT, 32'd7);
    wr(A_CTRL, 32'h8);
    chk_rd("pz_count6", A_COUNT, 32'd6);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk_rd("pz_hold", A_COUNT, 32'd6);
      chk_irq("pz_irq", 1'b0);
    end
    chk_rd("pz_ctrl", A_CTRL, 32'h8);
    wr(A_PRESET, 32'd2);
    chk_rd("pz_iso", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h9);
    tick(1);
    chk_rd("re_load", A_COUNT, 32'd6);
    tick(1);
    chk_rd("re_count2", A_COUNT, 32'd2);
    tick(1);
    chk_rd("re_count1", A_COUNT, 32'd1);
    chk_irq("re_irq_t3", 1'b0);
    tick(1);
    chk_irq("re_irq_t4", 1'b1);
    chk_rd("re_count0", A_COUNT, 32'd0);

    // CTRL write in the INT cycle: software value beats the EN clear
    wr(A_CTRL, 32'h9);
    chk_rd("sim_ctrl", A_CTRL, 32'h9);
    chk_irq("sim_irq", 1'b0);
    tick(1);
    chk_rd("sim_load", A_COUNT, 32'd0);
    tick(1);
    chk_rd("sim_count2", A_COUNT, 32'd2);
    tick(1);
    chk_irq("sim_irq_pre", 1'b0);
    // PRESET write in the cycle pending is set: pending survives
    wr(A_PRESET, 32'd2);
    chk_irq("sim_set_wins", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("sim_clr", 1'b0);
    chk_rd("sim_ctrl_end", A_CTRL, 32'h8);

    // PRESET = 0 with masked interrupt
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk_irq("z_irq", 1'b0);
      chk_rd("z_count", A_COUNT, 32'd0);
    end
    chk_rd("z_ctrl", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h8);
    chk_irq("z_im_irq", 1'b0);
    tick(1);
    chk_irq("z_im_irq2", 1'b0);

    // PRESET = 0 behaves as 1: IRQ three cycles after enable
    wr(A_CTRL, 32'h9);
    tick(2);
    chk_irq("z1_irq_t2", 1'b0);
    tick(1);
    chk_irq("z1_irq_t3", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("z1_clr", 1'b0);

    // Byte-lane write to PRESET
    wr(A_PRESET, 32'h1122_3344);
    wr(A_PRESET, 32'hAABB_CCDD, 4'b0010);
`ifdef TIMER_BYTE_WRITE_EN
    exp_p = 32'h1122_CC44;
`else
    exp_p = 32'hAABB_CCDD;
`endif
    chk_rd("bw_preset", A_PRESET, exp_p);

    // Reset in the middle of a count
    wr(A_CTRL, 32'hB);
    tick(4);
    chk_rd("mr_count", A_COUNT, exp_p - 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_rd("mr_ctrl",   A_CTRL,   32'h0);
    chk_rd("mr_preset", A_PRESET, 32'h0);
    chk_rd("mr_count0", A_COUNT,  32'h0);
    chk_rd("mr_rsvd",   A_RSVD,   32'h0);
    chk_irq("mr_irq", 1'b0);
    tick(3);
    chk_rd("mr_idle", A_COUNT, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds to the CPU's M-stage data-memory stores and loads and raises an interrupt request when the count expires. It is the device-side end of the CPU data bus: the pipeline initiates word accesses with address, write enable, byte enables and write data, and this block decodes, accepts and answers them. A system bridge decodes the base address and drives the select; the timer sees only word offsets.

## Interface
- No parameters.
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- Addr  input  2  word offset, Addr[3:2] of the CPU address; 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- WE  input  1  write strobe; already qualified by the bridge select.
- BE  input  4  byte enables from the store-width logic; BE[i] covers Din[8i+7:8i].
- Din  input  32  write data.
- Dout  output  32  read data; combinational from the registers.
- IRQ  output  1  interrupt request, equal to irq_pending & CTRL.IM.

## Operation
- CTRL register:
  - bit0 EN.
  - bits2:1 MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - bit3 IM, interrupt mask (1 = enabled).
  - bits31:4 read as 0 and ignore writes.
- PRESET: 32-bit read/write reload value.
- COUNT: 32-bit, read-only; writes to it are ignored.
- Offset 3 reads 0 and ignores writes.
- FSM states are IDLE, LOAD, CNT and INT. Reset state is IDLE.
  - IDLE: if EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if EN = 0, go to IDLE and COUNT holds. Else if COUNT <= 1, COUNT <= 0, irq_pending <= 1 and go to INT. Else COUNT <= COUNT - 1.
  - INT, mode 00: CTRL.EN <= 0, go to IDLE, irq_pending holds.
  - INT, mode 01: irq_pending <= 0, go to LOAD.
- Interrupt clearing: in mode 00, irq_pending clears on any write to CTRL or PRESET. In mode 01 it is a 1-cycle pulse.
- PRESET written during CNT does not affect COUNT until the next LOAD.
- PRESET = 0 behaves as PRESET = 1; COUNT does not wrap.
- Simultaneous events:
  - A software CTRL write in the same cycle as the INT hardware clear of EN: the software value wins.
  - A CTRL or PRESET write in the same cycle as irq_pending being set: pending ends at 1.
- Reset mid-count: next state is IDLE; CTRL, PRESET, COUNT and irq_pending all become 0; IRQ = 0.

## Timing
- Writes take effect at the clock edge on which WE = 1.
- Reads have zero latency. Dout reflects register values before that edge, so the CPU latches it into the W-stage register on the same edge.
- Let the CTRL write enabling the timer occur at edge t0, with PRESET = N, N >= 1:
  - t1: state LOAD.
  - t2: COUNT = N, state CNT.
  - t2+k: COUNT = N-k.
  - t2+N-1: COUNT = 1.
  - t2+N: COUNT = 0, state INT, IRQ = 1 (if IM).
- IRQ first asserts N+2 cycles after the enabling write.
- Auto-reload period is N+2 cycles: 1 cycle INT, 1 cycle LOAD, N cycles CNT. Each IRQ pulse is exactly 1 cycle wide.
- No stall or handshake: every access completes in one cycle.

## Configuration
- The macro is TIMER_BYTE_WRITE_EN.
- Defined: CTRL and PRESET update only the bytes whose BE bit is set. BE = 0000 with WE = 1 writes nothing but still counts as a write for clearing irq_pending.
- Undefined: BE is ignored and every write with WE = 1 replaces all 32 bits.

## Test plan
- Reset check: assert reset for 2 cycles. Expect Dout = 0 at all offsets and IRQ = 0.
- One-shot with interrupt: PRESET = 5, then CTRL = 0x9 (EN, mode 00, IM).
  - IRQ rises exactly 7 cycles after the CTRL write edge.
  - COUNT reads 5, 4, 3, 2, 1, 0.
  - CTRL reads 0x8.
  - IRQ stays high until CTRL is written with 0x8, then drops on the next edge.
- Auto-reload: PRESET = 3, CTRL = 0xB. Expect 1-cycle IRQ pulses every 5 cycles, first at t0+5; COUNT sequence 3, 2, 1, 0 repeating.
- Pause and PRESET isolation:
  - PRESET = 10, enable, then write CTRL.EN = 0 when COUNT = 6. COUNT holds at 6 and no IRQ occurs.
  - Write PRESET = 2 while paused, then re-enable. COUNT reloads to 2, not 6; IRQ follows 4 cycles after re-enable.
- PRESET = 0 plus masked interrupt: CTRL = 0x1. COUNT goes to 0, EN clears and IRQ stays 0. Setting IM afterwards (CTRL = 0x8) clears pending, so IRQ remains 0.
- Byte writes and reset mid-count:
  - With TIMER_BYTE_WRITE_EN defined: PRESET = 0x11223344, then write Din = 0xAABBCCDD with BE = 0010. PRESET reads 0x1122CC44.
  - With the macro undefined, the same write gives 0xAABBCCDD.
  - Reset during CNT returns every register to 0 on the next edge.
